// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock datapath: BCD digit width,
// per-digit maxima, the reset time and the legal-time check used on loads.
package alarm_clock_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_t;

   localparam bcd_t MAX_LS_MIN     = 4'd9;
   localparam bcd_t MAX_MS_MIN     = 4'd5;
   localparam bcd_t MAX_HR_LS      = 4'd9;
   localparam bcd_t MAX_HR_MS      = 4'd2;
   localparam bcd_t MAX_HR_LS_AT_2 = 4'd3;

   typedef struct packed {
      bcd_t ms_hr;
      bcd_t ls_hr;
      bcd_t ms_min;
      bcd_t ls_min;
   } hhmm_t;

   localparam hhmm_t RESET_TIME = '{ms_hr: 4'd0, ls_hr: 4'd0, ms_min: 4'd0, ls_min: 4'd0};

   // True when the time is a real 24-hour HH:MM value.
   function automatic logic load_valid(input hhmm_t t);
      logic ok;
      ok = (t.ls_min <= MAX_LS_MIN) && (t.ms_min <= MAX_MS_MIN) &&
           (t.ls_hr <= MAX_HR_LS) && (t.ms_hr <= MAX_HR_MS);
      if (t.ms_hr == MAX_HR_MS && t.ls_hr > MAX_HR_LS_AT_2)
         ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with load, increment and forced wrap. Any value at or above
// MAX rolls to 0 and carries, so out-of-range loads can never lock the digit.
module bcd_digit_counter
   import alarm_clock_pkg::*;
#(
   parameter bcd_t MAX     = 4'd9,
   parameter bcd_t RST_VAL = 4'd0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inc,
   input  logic       load,
   input  bcd_t       load_val,
   input  logic       wrap_force,
   output bcd_t       digit,
   output logic       carry_out
);

   logic at_top;

   assign at_top    = (digit >= MAX) || wrap_force;
   assign carry_out = inc && at_top;

   always_ff @(posedge clock) begin
      if (reset)
         digit <= RST_VAL;
      else if (load)
         digit <= load_val;
      else if (inc)
         digit <= at_top ? '0 : digit + 1'b1;
   end

endmodule

// File: rtl/time_counter.sv
// 24-hour HH:MM time-of-day counter in BCD. Advances one minute per one_minute
// cycle, accepts full-time loads, and flags day rollover and rejected loads.
module time_counter
   import alarm_clock_pkg::*;
#(
   parameter bit LOAD_CHECK = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               one_minute,
   input  logic               load_new_c,
   input  logic [DIGIT_W-1:0] new_current_time_ms_hr,
   input  logic [DIGIT_W-1:0] new_current_time_ls_hr,
   input  logic [DIGIT_W-1:0] new_current_time_ms_min,
   input  logic [DIGIT_W-1:0] new_current_time_ls_min,
   output logic [DIGIT_W-1:0] current_time_ms_hr,
   output logic [DIGIT_W-1:0] current_time_ls_hr,
   output logic [DIGIT_W-1:0] current_time_ms_min,
   output logic [DIGIT_W-1:0] current_time_ls_min,
   output logic               day_wrap,
   output logic               load_err
);

   hhmm_t new_time;
   logic  load_ok;
   logic  load_go;
   logic  advance;
   logic  hr_wrap;
   logic  c_ls_min;
   logic  c_ms_min;
   logic  c_ls_hr;
   logic  c_ms_hr;

   assign new_time = {new_current_time_ms_hr, new_current_time_ls_hr,
                      new_current_time_ms_min, new_current_time_ls_min};
   assign load_ok  = !LOAD_CHECK || load_valid(new_time);
   assign load_go  = load_new_c && load_ok;
   // A load, accepted or not, swallows a coincident minute pulse.
   assign advance  = one_minute && !load_new_c;
   // Hours 2x with x >= 3 (including illegal 24..29) roll straight to 00.
   assign hr_wrap  = (current_time_ms_hr >= MAX_HR_MS) && (current_time_ls_hr >= MAX_HR_LS_AT_2);

   bcd_digit_counter #(.MAX(MAX_LS_MIN), .RST_VAL(RESET_TIME.ls_min)) u_ls_min (
      .clock(clock), .reset(reset), .inc(advance), .load(load_go),
      .load_val(new_current_time_ls_min), .wrap_force(1'b0),
      .digit(current_time_ls_min), .carry_out(c_ls_min)
   );

   bcd_digit_counter #(.MAX(MAX_MS_MIN), .RST_VAL(RESET_TIME.ms_min)) u_ms_min (
      .clock(clock), .reset(reset), .inc(c_ls_min), .load(load_go),
      .load_val(new_current_time_ms_min), .wrap_force(1'b0),
      .digit(current_time_ms_min), .carry_out(c_ms_min)
   );

   bcd_digit_counter #(.MAX(MAX_HR_LS), .RST_VAL(RESET_TIME.ls_hr)) u_ls_hr (
      .clock(clock), .reset(reset), .inc(c_ms_min), .load(load_go),
      .load_val(new_current_time_ls_hr), .wrap_force(hr_wrap),
      .digit(current_time_ls_hr), .carry_out(c_ls_hr)
   );

   bcd_digit_counter #(.MAX(MAX_HR_MS), .RST_VAL(RESET_TIME.ms_hr)) u_ms_hr (
      .clock(clock), .reset(reset), .inc(c_ls_hr), .load(load_go),
      .load_val(new_current_time_ms_hr), .wrap_force(hr_wrap),
      .digit(current_time_ms_hr), .carry_out(c_ms_hr)
   );

   // A carry out of the tens-of-hours digit only happens on the roll to 00:00.
   always_ff @(posedge clock) begin
      if (reset) begin
         day_wrap <= 1'b0;
         load_err <= 1'b0;
      end else begin
         day_wrap <= c_ms_hr;
         load_err <= load_new_c && !load_ok;
      end
   end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: one checked and one unchecked instance run
// side by side against a minute-of-day model, plus literal expectations.
module tb_time_counter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        one_minute = 1'b0;
   logic        load_new_c = 1'b0;
   logic [15:0] new_t = 16'h0000;

   logic [3:0] chk_mh, chk_lh, chk_mm, chk_lm, raw_mh, raw_lh, raw_mm, raw_lm;
   logic       chk_dw, chk_le, raw_dw, raw_le;

   logic [15:0] dut_t [2];
   logic        dut_dw [2];
   logic        dut_le [2];

   logic [15:0] m_t [2];
   logic        m_dw [2];
   logic        m_le [2];

   int   n_checks = 0;
   int   n_fail = 0;
   logic check_en = 1'b0;
   int   dw_seen;

   logic [15:0] exp_run [5] = '{16'h0058, 16'h0059, 16'h0100, 16'h0101, 16'h0102};

   always #5 clock = ~clock;

   time_counter #(.LOAD_CHECK(1'b1)) dut_chk (
      .clock(clock), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
      .new_current_time_ms_hr(new_t[15:12]), .new_current_time_ls_hr(new_t[11:8]),
      .new_current_time_ms_min(new_t[7:4]), .new_current_time_ls_min(new_t[3:0]),
      .current_time_ms_hr(chk_mh), .current_time_ls_hr(chk_lh),
      .current_time_ms_min(chk_mm), .current_time_ls_min(chk_lm),
      .day_wrap(chk_dw), .load_err(chk_le)
   );

   time_counter #(.LOAD_CHECK(1'b0)) dut_raw (
      .clock(clock), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
      .new_current_time_ms_hr(new_t[15:12]), .new_current_time_ls_hr(new_t[11:8]),
      .new_current_time_ms_min(new_t[7:4]), .new_current_time_ls_min(new_t[3:0]),
      .current_time_ms_hr(raw_mh), .current_time_ls_hr(raw_lh),
      .current_time_ms_min(raw_mm), .current_time_ls_min(raw_lm),
      .day_wrap(raw_dw), .load_err(raw_le)
   );

   assign dut_t[0]  = {chk_mh, chk_lh, chk_mm, chk_lm};
   assign dut_t[1]  = {raw_mh, raw_lh, raw_mm, raw_lm};
   assign dut_dw[0] = chk_dw;
   assign dut_dw[1] = raw_dw;
   assign dut_le[0] = chk_le;
   assign dut_le[1] = raw_le;

   function automatic logic legal(input logic [15:0] t);
      return (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9) &&
             !((t[15:12] == 4'd2) && (t[11:8] > 4'd3));
   endfunction

   // Returns {day_wrap, next_time}.
   function automatic logic [16:0] model_advance(input logic [15:0] t);
      int   mh, lh, mm, lm, tot;
      logic w;
      mh = int'(t[15:12]);
      lh = int'(t[11:8]);
      mm = int'(t[7:4]);
      lm = int'(t[3:0]);
      w  = 1'b0;
      if (legal(t)) begin
         tot = (mh * 10 + lh) * 60 + mm * 10 + lm + 1;
         if (tot == 1440) begin
            tot = 0;
            w   = 1'b1;
         end
         mh = tot / 600;
         lh = (tot / 60) % 10;
         mm = (tot % 60) / 10;
         lm = tot % 10;
      end else begin
         // Out-of-range digits behave as their maximum: roll to 0 and carry.
         if (lm < 9) lm++;
         else begin
            lm = 0;
            if (mm < 5) mm++;
            else begin
               mm = 0;
               if (mh >= 2 && lh >= 3) begin
                  mh = 0;
                  lh = 0;
                  w  = 1'b1;
               end else if (lh < 9) lh++;
               else begin
                  lh = 0;
                  mh = mh + 1;
               end
            end
         end
      end
      return {w, 4'(mh), 4'(lh), 4'(mm), 4'(lm)};
   endfunction

   always @(posedge clock) begin
      logic [16:0] r;
      for (int k = 0; k < 2; k++) begin
         m_dw[k] = 1'b0;
         m_le[k] = 1'b0;
         if (reset)
            m_t[k] = 16'h0000;
         else if (load_new_c) begin
            if (k == 1 || legal(new_t)) m_t[k] = new_t;
            else                        m_le[k] = 1'b1;
         end else if (one_minute) begin
            r       = model_advance(m_t[k]);
            m_t[k]  = r[15:0];
            m_dw[k] = r[16];
         end
      end
   end

   task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (check_en) begin
         for (int k = 0; k < 2; k++) begin
            check_val($sformatf("time[%0d]", k), dut_t[k], m_t[k]);
            check_val($sformatf("day_wrap[%0d]", k), 16'(dut_dw[k]), 16'(m_dw[k]));
            check_val($sformatf("load_err[%0d]", k), 16'(dut_le[k]), 16'(m_le[k]));
         end
      end
   end

   task automatic check_time(input string name, input int k, input logic [15:0] exp);
      check_val(name, dut_t[k], exp);
      check_val({name, "_model"}, m_t[k], exp);
   endtask

   task automatic step(input logic rst, input logic ld, input logic [15:0] t, input logic om);
      reset      = rst;
      load_new_c = ld;
      new_t      = t;
      one_minute = om;
      @(negedge clock);
      reset      = 1'b0;
      load_new_c = 1'b0;
      one_minute = 1'b0;
   endtask

   initial begin
      @(negedge clock);
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check_en = 1'b1;
      check_time("reset_time", 0, 16'h0000);
      check_val("reset_dw", 16'(chk_dw), 16'h0);
      check_val("reset_le", 16'(chk_le), 16'h0);

      // 60 pulses, one every 4th cycle.
      dw_seen = 0;
      for (int i = 0; i < 60; i++) begin
         step(1'b0, 1'b0, 16'h0000, 1'b1);
         if (chk_dw) dw_seen++;
         if (i == 58) check_time("t0059", 0, 16'h0059);
         for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0);
            if (chk_dw) dw_seen++;
         end
      end
      check_time("t0100", 0, 16'h0100);
      check_val("no_day_wrap", 16'(dw_seen), 16'h0);

      // Day rollover.
      step(1'b0, 1'b1, 16'h2358, 1'b0);
      check_time("ld2358", 0, 16'h2358);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      check_time("t2359", 0, 16'h2359);
      check_val("dw_at_2359", 16'(chk_dw), 16'h0);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      check_time("t0000", 0, 16'h0000);
      check_val("dw_at_0000", 16'(chk_dw), 16'h1);
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      check_val("dw_drop", 16'(chk_dw), 16'h0);

      // Hour digit carry paths.
      step(1'b0, 1'b1, 16'h0959, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      check_time("t1000", 0, 16'h1000);
      step(1'b0, 1'b1, 16'h1959, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      check_time("t2000", 0, 16'h2000);

      // Rejected loads on the checked instance, verbatim on the raw one.
      step(1'b0, 1'b1, 16'h1234, 1'b0);
      step(1'b0, 1'b1, 16'h1260, 1'b0);
      check_time("rej1260", 0, 16'h1234);
      check_val("le_1260", 16'(chk_le), 16'h1);
      check_time("raw1260", 1, 16'h1260);
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      check_val("le_drop", 16'(chk_le), 16'h0);
      step(1'b0, 1'b1, 16'h2400, 1'b0);
      check_time("rej2400", 0, 16'h1234);
      check_val("le_2400", 16'(chk_le), 16'h1);
      check_time("raw2400", 1, 16'h2400);
      for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
      check_time("raw_2400_plus60", 1, 16'h0000);
      check_val("raw_dw_2459", 16'(raw_dw), 16'h1);
      check_time("chk_1234_plus60", 0, 16'h1334);

      // Load beats a coincident pulse; reset beats a coincident pulse.
      step(1'b0, 1'b1, 16'h1234, 1'b1);
      check_time("ld_vs_pulse", 0, 16'h1234);
      check_time("ld_vs_pulse_raw", 1, 16'h1234);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      check_time("rst_vs_pulse", 0, 16'h0000);

      // Back-to-back pulses.
      step(1'b0, 1'b1, 16'h0057, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 16'h0000, 1'b1);
         check_time($sformatf("run%0d", i), 0, exp_run[i]);
      end

      // Fully illegal load 27:6A.
      step(1'b0, 1'b1, 16'h276A, 1'b0);
      check_val("le_276A", 16'(chk_le), 16'h1);
      check_time("raw276A", 1, 16'h276A);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      check_time("raw276A_inc", 1, 16'h0000);
      check_val("raw_dw_276A", 16'(raw_dw), 16'h1);
      check_time("chk_0103", 0, 16'h0103);
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b0);

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
